// File: rtl/led_sequencer_pkg.sv
// Shared encodings for the LED sequencer: pattern modes and bounce direction.
package led_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_ROTATE = 2'b00,
    MODE_BOUNCE = 2'b01,
    MODE_COUNT  = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

endpackage

// File: rtl/led_sequencer_tick_gen.sv
// Prescaler: emits a combinational step once every 2^N enabled clock cycles.
module led_sequencer_tick_gen #(
  parameter int N = 3
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic en_in,
  output logic step
);

  logic [N-1:0] cnt_reg;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_reg <= '0;
    end else if (en_in) begin
      cnt_reg <= cnt_reg + N'(1);
    end
  end

  assign step = en_in & (cnt_reg == {N{1'b1}});

endmodule

// File: rtl/led_sequencer.sv
// Parametrised LED pattern generator: rotate, bounce, binary count and blink,
// advancing one pattern step per prescaler tick.
module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int N     = 3
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             en_in,
  input  logic [1:0]       mode_in,
  output logic [WIDTH-1:0] data,
  output logic             tick_out
);

  logic             step;
  mode_t            mode_reg, mode_next;
  dir_t             dir_reg, dir_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             tick_reg;
  logic [WIDTH-1:0] rot_left, shl, shr, init_pattern;

  led_sequencer_tick_gen #(.N(N)) u_tick_gen (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .en_in    (en_in),
    .step     (step)
  );

  // Shift/rotate networks; zero fill at the ends keeps them valid for WIDTH=1.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
    assign rot_left[gi] = data_reg[(gi + WIDTH - 1) % WIDTH];
    if (gi == 0) begin : g_shl_lo
      assign shl[gi] = 1'b0;
    end else begin : g_shl_hi
      assign shl[gi] = data_reg[gi-1];
    end
    if (gi == WIDTH - 1) begin : g_shr_hi
      assign shr[gi] = 1'b0;
    end else begin : g_shr_lo
      assign shr[gi] = data_reg[gi+1];
    end
  end

  always_comb begin
    init_pattern = '0;
    case (mode_t'(mode_in))
      MODE_ROTATE: init_pattern = WIDTH'(1);
      MODE_BOUNCE: init_pattern = WIDTH'(1);
      MODE_COUNT:  init_pattern = '0;
      MODE_BLINK:  init_pattern = '1;
      default:     init_pattern = '0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mode_reg <= MODE_ROTATE;
      dir_reg  <= DIR_LEFT;
      data_reg <= WIDTH'(1);
      tick_reg <= 1'b0;
    end else begin
      mode_reg <= mode_next;
      dir_reg  <= dir_next;
      data_reg <= data_next;
      tick_reg <= step;
    end
  end

  // A mode change only reloads the pattern; advancing waits for the next step.
  always_comb begin
    mode_next = mode_reg;
    dir_next  = dir_reg;
    data_next = data_reg;
    if (step) begin
      if (mode_t'(mode_in) != mode_reg) begin
        mode_next = mode_t'(mode_in);
        dir_next  = DIR_LEFT;
        data_next = init_pattern;
      end else begin
        case (mode_reg)
          MODE_ROTATE: data_next = rot_left;
          MODE_BOUNCE: begin
            if (WIDTH > 1) begin
              if (dir_reg == DIR_LEFT) begin
                data_next = shl;
                if (shl[WIDTH-1]) dir_next = DIR_RIGHT;
              end else begin
                data_next = shr;
                if (shr[0]) dir_next = DIR_LEFT;
              end
            end
          end
          MODE_COUNT:  data_next = data_reg + WIDTH'(1);
          MODE_BLINK:  data_next = ~data_reg;
          default:     data_next = data_reg;
        endcase
      end
    end
  end

  always_comb begin
    data     = data_reg;
    tick_out = tick_reg;
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer (WIDTH=4, N=3): directed vector table,
// async-reset sequence, then randomized run against a phase-based reference model.
module tb_led_sequencer;

  localparam int W = 4;
  localparam int P = 8;  // 2^N

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] data;
  logic         tick;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pattern expressed as mode plus number of steps since reload.
  int m_cnt, m_mode, m_phase;
  bit m_tick;

  typedef struct {
    logic         en;
    logic [1:0]   mode;
    int           ncyc;
    logic [W-1:0] exp_data;
    logic         exp_tick;
  } vec_t;

  vec_t vecs[$];

  led_sequencer #(.WIDTH(W), .N(3)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .en_in    (en),
    .mode_in  (mode),
    .data     (data),
    .tick_out (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_mode = 0; m_phase = 0; m_tick = 0;
  endtask

  function automatic logic [W-1:0] model_data();
    int p;
    case (m_mode)
      0: return W'(1 << (m_phase % W));
      1: begin
        p = m_phase % (2*W - 2);
        return W'(1 << ((p < W) ? p : (2*W - 2 - p)));
      end
      2: return W'(m_phase % (1 << W));
      default: return (m_phase % 2 == 1) ? W'(0) : {W{1'b1}};
    endcase
  endfunction

  // One clock: model follows the inputs held across the edge; returns #1 after it.
  task automatic clk_step();
    bit s;
    @(posedge clk);
    s = en && (m_cnt == P - 1);
    if (en) m_cnt = (m_cnt + 1) % P;
    if (s) begin
      if (int'(mode) != m_mode) begin
        m_mode  = int'(mode);
        m_phase = 0;
      end else begin
        m_phase++;
      end
    end
    m_tick = s;
    #1;
  endtask

  function automatic vec_t mk(logic e, logic [1:0] m, int n, logic [W-1:0] d, logic t);
    vec_t v;
    v.en = e; v.mode = m; v.ncyc = n; v.exp_data = d; v.exp_tick = t;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; en = 1'b1; mode = 2'b00;
    model_reset();

    // ROTATE from reset, with tick timing around the first step
    vecs.push_back(mk(1, 2'b00, 7, 4'b0001, 0));
    vecs.push_back(mk(1, 2'b00, 1, 4'b0010, 1));
    vecs.push_back(mk(1, 2'b00, 1, 4'b0010, 0));
    vecs.push_back(mk(1, 2'b00, 7, 4'b0100, 1));
    vecs.push_back(mk(1, 2'b00, 8, 4'b1000, 1));
    vecs.push_back(mk(1, 2'b00, 8, 4'b0001, 1));
    // BOUNCE: reload without advance, then one pass each way
    vecs.push_back(mk(1, 2'b01, 8, 4'b0001, 1));
    vecs.push_back(mk(1, 2'b01, 8, 4'b0010, 1));
    vecs.push_back(mk(1, 2'b01, 8, 4'b0100, 1));
    vecs.push_back(mk(1, 2'b01, 8, 4'b1000, 1));
    vecs.push_back(mk(1, 2'b01, 8, 4'b0100, 1));
    vecs.push_back(mk(1, 2'b01, 8, 4'b0010, 1));
    vecs.push_back(mk(1, 2'b01, 8, 4'b0001, 1));
    vecs.push_back(mk(1, 2'b01, 8, 4'b0010, 1));
    // COUNT: reload 0, count through 15, wrap to 0
    vecs.push_back(mk(1, 2'b10, 8, 4'b0000, 1));
    for (int i = 1; i <= 16; i++) vecs.push_back(mk(1, 2'b10, 8, W'(i % 16), 1));
    // BLINK
    vecs.push_back(mk(1, 2'b11, 8, 4'b1111, 1));
    vecs.push_back(mk(1, 2'b11, 8, 4'b0000, 1));
    vecs.push_back(mk(1, 2'b11, 8, 4'b1111, 1));
    // Freeze mid-period for 20 clocks, then finish the remaining count
    vecs.push_back(mk(1, 2'b11, 3, 4'b1111, 0));
    vecs.push_back(mk(0, 2'b11, 20, 4'b1111, 0));
    vecs.push_back(mk(1, 2'b11, 4, 4'b1111, 0));
    vecs.push_back(mk(1, 2'b11, 1, 4'b0000, 1));
    // mode_in change between steps is ignored
    vecs.push_back(mk(1, 2'b00, 4, 4'b0000, 0));
    vecs.push_back(mk(1, 2'b11, 3, 4'b0000, 0));
    vecs.push_back(mk(1, 2'b11, 1, 4'b1111, 1));

    #12;
    check("reset_data", data, 4'b0001);
    check("reset_tick", {3'b0, tick}, 4'b0000);
    @(posedge clk); #2;
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      en = vecs[i].en; mode = vecs[i].mode;
      for (int c = 0; c < vecs[i].ncyc; c++) clk_step();
      check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
      check($sformatf("vec%0d_tick", i), {3'b0, tick}, {3'b0, vecs[i].exp_tick});
    end

    // COUNT to 0101, then asynchronous reset between edges
    en = 1'b1; mode = 2'b10;
    for (int c = 0; c < 6*P; c++) clk_step();
    check("count_0101", data, 4'b0101);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_data", data, 4'b0001);
    check("async_rst_tick", {3'b0, tick}, 4'b0000);
    model_reset();
    #1 rst_n = 1'b1;
    mode = 2'b00;
    for (int c = 0; c < P - 1; c++) clk_step();
    check("post_rst_hold", data, 4'b0001);
    clk_step();
    check("post_rst_step", data, 4'b0010);
    check("post_rst_tick", {3'b0, tick}, 4'b0001);

    // Randomized run against the reference model
    for (int c = 0; c < 600; c++) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 40) == 0) mode = 2'($urandom_range(0, 3));
      clk_step();
      check("rand_data", data, model_data());
      check("rand_tick", {3'b0, tick}, {3'b0, m_tick});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
